// File: rtl/pkg_accelerator.sv
// -----------------------------------------------------------------------------
// pkg_accelerator
// Shared widths, the per-tile requantisation configuration record and the
// control phase encoding used by the requantiser (requant_stage, requant_lane).
// -----------------------------------------------------------------------------
package pkg_accelerator;

    localparam int ARRAY_COLS        = 8;   // lanes per beat
    localparam int ACC_WIDTH         = 32;  // signed accumulator width per lane
    localparam int OUT_WIDTH         = 8;   // signed output width per lane
    localparam int QUANT_MULT_WIDTH  = 16;  // unsigned scale multiplier width
    localparam int QUANT_SHIFT_WIDTH = 5;   // right-shift amount width
    localparam int BEAT_CNT_WIDTH    = 16;  // tile beat counter width
    localparam int SAT_CNT_WIDTH     = 16;  // saturated-lane counter width

    // Full-precision product width: signed acc times zero-extended scale.
    localparam int PROD_WIDTH     = ACC_WIDTH + QUANT_MULT_WIDTH + 1;
    // Enough bits to hold the number of saturated lanes in one beat.
    localparam int LANE_CNT_WIDTH = $clog2(ARRAY_COLS + 1);

    typedef struct packed {
        logic [QUANT_MULT_WIDTH-1:0]  scale;
        logic [QUANT_SHIFT_WIDTH-1:0] shift;
        logic [OUT_WIDTH-1:0]         zero_point;  // two's complement
        logic                         relu_en;
        logic [BEAT_CNT_WIDTH-1:0]    tile_beats;  // 0 behaves as 1
    } quant_cfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } phase_e;

    // Number of set bits in a per-lane flag vector.
    function automatic logic [LANE_CNT_WIDTH-1:0] count_ones(input logic [ARRAY_COLS-1:0] flags);
        logic [LANE_CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < ARRAY_COLS; i++) begin
            cnt = cnt + LANE_CNT_WIDTH'(flags[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// -----------------------------------------------------------------------------
// requant_lane
// One lane of the requantiser: INT32 accumulator -> INT8 in three registered
// stages sharing a single advance enable.
//   S1: p = acc * scale                      (full precision)
//   S2: r = (p + 2^(shift-1)) >>> shift      (round half toward +inf; r = p if shift == 0)
//   S3: optional ReLU, add zero point, saturate to the signed output range
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en_i           advance all three stages; hold everything when low
//   acc_i          signed accumulator
//   scale_i        unsigned multiplier
//   shift_i        rounding right-shift amount
//   zero_point_i   signed output offset
//   relu_en_i      clamp negative shifted results to zero before the offset
//   q_o            registered S3 result
//   sat_o          combinational: the value entering S3 lies outside the output range
// -----------------------------------------------------------------------------
module requant_lane
    import pkg_accelerator::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic [ACC_WIDTH-1:0]         acc_i,
    input  logic [QUANT_MULT_WIDTH-1:0]  scale_i,
    input  logic [QUANT_SHIFT_WIDTH-1:0] shift_i,
    input  logic [OUT_WIDTH-1:0]         zero_point_i,
    input  logic                         relu_en_i,
    output logic [OUT_WIDTH-1:0]         q_o,
    output logic                         sat_o
);

    localparam int PW = PROD_WIDTH;
    localparam int SW = PROD_WIDTH + 1;  // one guard bit for the rounding/offset adds

    localparam logic signed [SW-1:0] OUT_MAX = SW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] OUT_MIN = -OUT_MAX - SW'(1);
    localparam logic signed [SW-1:0] ONE     = SW'(1);

    logic signed [PW-1:0]  acc_ext;
    logic signed [PW-1:0]  scale_ext;
    logic signed [PW-1:0]  prod_d, prod_q;
    logic signed [SW-1:0]  round_sum;
    logic signed [PW-1:0]  shr_d, shr_q;
    logic signed [PW-1:0]  relu_val;
    logic signed [SW-1:0]  offs_val;
    logic                  sat_hi, sat_lo;
    logic [OUT_WIDTH-1:0]  q_d, q_q;

    // S1: product of sign-extended accumulator and zero-extended scale; the
    // true product always fits PW bits, so the truncated result is exact.
    always_comb begin
        acc_ext   = {{(PW - ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
        scale_ext = {{(PW - QUANT_MULT_WIDTH){1'b0}}, scale_i};
        prod_d    = acc_ext * scale_ext;
    end

    // S2: add half an LSB of the result, then arithmetic shift. The rounding
    // term is computed for shift == 0 as well but is not selected there.
    always_comb begin
        round_sum = {prod_q[PW-1], prod_q} + (ONE <<< (shift_i - QUANT_SHIFT_WIDTH'(1)));
        if (shift_i != '0) begin
            shr_d = PW'(round_sum >>> shift_i);
        end else begin
            shr_d = prod_q;
        end
    end

    // S3: ReLU acts before the zero point, so a clamped lane outputs exactly zp.
    // NOTE: every always_comb output gets a value on every path; the
    // unconditional assignments here (and defaults-first elsewhere) are what
    // keep synthesis from inferring latches.
    always_comb begin
        relu_val = (relu_en_i && shr_q[PW-1]) ? '0 : shr_q;
        offs_val = {relu_val[PW-1], relu_val}
                 + {{(SW - OUT_WIDTH){zero_point_i[OUT_WIDTH-1]}}, zero_point_i};
        sat_hi   = offs_val > OUT_MAX;
        sat_lo   = offs_val < OUT_MIN;
        if (sat_hi) begin
            q_d = OUT_MAX[OUT_WIDTH-1:0];
        end else if (sat_lo) begin
            q_d = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            q_d = offs_val[OUT_WIDTH-1:0];
        end
    end

    // NOTE: datapath registers are reset as well, because the registered S3
    // value drives data_out_packed directly and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            shr_q  <= '0;
            q_q    <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
            shr_q  <= shr_d;
            q_q    <= q_d;
        end
    end

    assign q_o   = q_q;
    assign sat_o = sat_hi | sat_lo;

endmodule

// File: rtl/requant_stage.sv
// -----------------------------------------------------------------------------
// requant_stage
// Pipelined requantiser between the accumulator drain and the AXI4-Stream
// output. Each beat carries ARRAY_COLS signed INT32 accumulators and leaves as
// ARRAY_COLS INT8 lanes three cycles later; the final beat of a tile is tagged
// with data_last. A single enable stalls the whole pipeline under downstream
// backpressure, so no beat is dropped.
// Build option: define REQUANT_SAT_COUNT_EN to count saturated lanes per tile
// on sat_count; otherwise sat_count is tied to 0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse; in IDLE latches cfg_* and begins a tile
//   cfg_scale/shift/zero_point/relu_en/tile_beats   per-tile configuration
//   acc_in_packed     lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   acc_valid/ready   input beat handshake
//   data_out_packed   lane i at [i*OUT_WIDTH +: OUT_WIDTH]
//   data_valid/ready  output beat handshake
//   data_last         final beat of the tile, qualified by data_valid
//   busy              tile in progress
//   sat_count         saturated lanes in the current/last tile
// -----------------------------------------------------------------------------
module requant_stage
    import pkg_accelerator::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [QUANT_MULT_WIDTH-1:0]      cfg_scale,
    input  logic [QUANT_SHIFT_WIDTH-1:0]     cfg_shift,
    input  logic [OUT_WIDTH-1:0]             cfg_zero_point,
    input  logic                             cfg_relu_en,
    input  logic [BEAT_CNT_WIDTH-1:0]        cfg_tile_beats,
    input  logic [ACC_WIDTH*ARRAY_COLS-1:0]  acc_in_packed,
    input  logic                             acc_valid,
    output logic                             acc_ready,
    output logic [OUT_WIDTH*ARRAY_COLS-1:0]  data_out_packed,
    output logic                             data_valid,
    output logic                             data_last,
    input  logic                             data_ready,
    output logic                             busy,
    output logic [SAT_CNT_WIDTH-1:0]         sat_count
);

    phase_e                    state_q, state_d;
    quant_cfg_t                cfg_q, cfg_d;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_CNT_WIDTH-1:0] last_idx;
    logic                      in_done_q, in_done_d;

    logic                      en;
    logic                      start_accept;
    logic                      in_fire;
    logic                      beat_is_last;
    logic                      final_out_fire;

    // Valid/last tags travel alongside the lane datapath, one bit per stage.
    logic                      s1_valid_q, s2_valid_q, s3_valid_q;
    logic                      s1_last_q,  s2_last_q,  s3_last_q;

    logic [ARRAY_COLS-1:0]     lane_sat;

    // Everything advances together when the output slot is empty or draining.
    assign en             = !s3_valid_q || data_ready;
    assign start_accept   = start && (state_q == ST_IDLE);
    assign in_fire        = acc_valid && acc_ready;
    assign last_idx       = (cfg_q.tile_beats == '0) ? '0
                                                     : cfg_q.tile_beats - BEAT_CNT_WIDTH'(1);
    assign beat_is_last   = (beat_cnt_q == last_idx);
    assign final_out_fire = s3_valid_q && data_ready && s3_last_q;

    // Control: next phase, beat counter, drain flag and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        beat_cnt_d = beat_cnt_q;
        in_done_d  = in_done_q;
        acc_ready  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d          = ST_RUN;
                    cfg_d.scale      = cfg_scale;
                    cfg_d.shift      = cfg_shift;
                    cfg_d.zero_point = cfg_zero_point;
                    cfg_d.relu_en    = cfg_relu_en;
                    cfg_d.tile_beats = cfg_tile_beats;
                    beat_cnt_d       = '0;
                    in_done_d        = 1'b0;
                end
            end

            ST_RUN: begin
                busy      = 1'b1;
                acc_ready = !in_done_q && en;
                // Input stops after the last beat; the tile ends only once
                // that beat has been taken downstream. start is ignored here.
                if (in_fire) begin
                    if (beat_is_last) begin
                        beat_cnt_d = '0;
                        in_done_d  = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_CNT_WIDTH'(1);
                    end
                end
                if (final_out_fire) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            beat_cnt_q <= '0;
            in_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            beat_cnt_q <= beat_cnt_d;
            in_done_q  <= in_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            s3_last_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= in_fire;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            s1_last_q  <= in_fire && beat_is_last;
            s2_last_q  <= s1_last_q;
            s3_last_q  <= s2_last_q;
        end
    end

    assign data_valid = s3_valid_q;
    assign data_last  = s3_last_q;

    for (genvar g = 0; g < ARRAY_COLS; g++) begin : g_lane
        requant_lane u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .en_i         (en),
            .acc_i        (acc_in_packed[g*ACC_WIDTH +: ACC_WIDTH]),
            .scale_i      (cfg_q.scale),
            .shift_i      (cfg_q.shift),
            .zero_point_i (cfg_q.zero_point),
            .relu_en_i    (cfg_q.relu_en),
            .q_o          (data_out_packed[g*OUT_WIDTH +: OUT_WIDTH]),
            .sat_o        (lane_sat[g])
        );
    end

`ifdef REQUANT_SAT_COUNT_EN
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;
    logic [SAT_CNT_WIDTH:0]   sat_sum;

    // Lane flags describe the values being registered into S3, so they are
    // counted exactly when a valid beat moves from S2 into S3.
    always_comb begin
        sat_sum   = {1'b0, sat_cnt_q} + (SAT_CNT_WIDTH + 1)'(count_ones(lane_sat));
        sat_cnt_d = sat_cnt_q;
        if (start_accept) begin
            sat_cnt_d = '0;
        end else if (en && s2_valid_q) begin
            sat_cnt_d = sat_sum[SAT_CNT_WIDTH] ? '1 : sat_sum[SAT_CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    logic unused_sat;
    assign unused_sat = ^{lane_sat, start_accept};
    assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_requant_stage.sv
// -----------------------------------------------------------------------------
// tb_requant_stage
// Directed bench for requant_stage. A reference model in the monitor computes
// each expected INT8 lane with plain integer arithmetic, tracks the tile phase
// and last-beat position, and checks every output handshake in order.
// Hand-computed literal beats pin the model to known values.
// -----------------------------------------------------------------------------
module tb_requant_stage;

`ifdef REQUANT_SAT_COUNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  cfg_scale;
    logic [4:0]   cfg_shift;
    logic [7:0]   cfg_zero_point;
    logic         cfg_relu_en;
    logic [15:0]  cfg_tile_beats;
    logic [255:0] acc_in_packed;
    logic         acc_valid;
    logic         acc_ready;
    logic [63:0]  data_out_packed;
    logic         data_valid;
    logic         data_last;
    logic         data_ready;
    logic         busy;
    logic [15:0]  sat_count;

    requant_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_scale       (cfg_scale),
        .cfg_shift       (cfg_shift),
        .cfg_zero_point  (cfg_zero_point),
        .cfg_relu_en     (cfg_relu_en),
        .cfg_tile_beats  (cfg_tile_beats),
        .acc_in_packed   (acc_in_packed),
        .acc_valid       (acc_valid),
        .acc_ready       (acc_ready),
        .data_out_packed (data_out_packed),
        .data_valid      (data_valid),
        .data_last       (data_last),
        .data_ready      (data_ready),
        .busy            (busy),
        .sat_count       (sat_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pop    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 64'(act), 64'(exp));
    endtask

    // Reference: exact integer maths with floor division for the rounding shift.
    function automatic logic [7:0] rq(input int acc, input int unsigned scale,
                                      input int unsigned shift, input int zp,
                                      input bit relu, output bit sat);
        longint p, num, d, r, v;
        p = longint'(acc) * longint'(scale);
        if (shift == 0) begin
            r = p;
        end else begin
            d = 1;
            for (int k = 0; k < int'(shift); k++) d = d * 2;
            num = p + d / 2;
            r = num / d;
            if ((num % d != 0) && (num < 0)) r = r - 1;
        end
        if (relu && r < 0) r = 0;
        v = r + longint'(zp);
        sat = (v > 127) || (v < -128);
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return v[7:0];
    endfunction

    function automatic logic [255:0] pk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    bit          m_run = 1'b0;
    int unsigned m_scale, m_shift, m_tb, m_idx, m_sat;
    int          m_zp;
    bit          m_relu;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;

    // Monitor: phase/last model, scoreboard push on input handshakes,
    // in-order compare on output handshakes, stall stability.
    always @(negedge clk) begin
        exp_t        e;
        bit          s;
        int unsigned eff, nsat;
        if (!rst_n) begin
            sb.delete();
            prev_stall = 1'b0;
            m_run      = 1'b0;
        end else begin
            check1("busy_phase", busy, m_run);
            if (start && !m_run) begin
                m_run   = 1'b1;
                m_scale = int'(cfg_scale);
                m_shift = int'(cfg_shift);
                m_zp    = int'($signed(cfg_zero_point));
                m_relu  = cfg_relu_en;
                m_tb    = int'(cfg_tile_beats);
                m_idx   = 0;
                m_sat   = 0;
            end
            if (acc_valid && acc_ready) begin
                nsat = 0;
                for (int i = 0; i < 8; i++) begin
                    e.data[i*8 +: 8] = rq($signed(acc_in_packed[i*32 +: 32]), m_scale, m_shift,
                                          m_zp, m_relu, s);
                    if (s) nsat++;
                end
                eff    = (m_tb == 0) ? 1 : m_tb;
                e.last = (m_idx == eff - 1);
                m_idx  = e.last ? 0 : m_idx + 1;
                m_sat  = (m_sat + nsat > 65535) ? 65535 : m_sat + nsat;
                sb.push_back(e);
            end
            if (prev_stall) begin
                check1("stall_valid", data_valid, 1'b1);
                check("stall_data", data_out_packed, prev_data);
                check1("stall_last", data_last, prev_last);
            end
            if (data_valid && !data_ready) check1("stall_acc_ready", acc_ready, 1'b0);
            if (data_valid && data_ready) begin
                if (sb.size() == 0) begin
                    check1("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", data_out_packed, e.data);
                    check1("beat_last", data_last, e.last);
                    n_pop++;
                    if (e.last) m_run = 1'b0;
                end
            end
            prev_stall = data_valid && !data_ready;
            prev_data  = data_out_packed;
            prev_last  = data_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int scale, input int shift, input int zp,
                            input bit relu, input int tb);
        cfg_scale      = scale[15:0];
        cfg_shift      = shift[4:0];
        cfg_zero_point = zp[7:0];
        cfg_relu_en    = relu;
        cfg_tile_beats = tb[15:0];
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    task automatic send(input logic [255:0] beat);
        bit got = 1'b0;
        acc_in_packed = beat;
        acc_valid     = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = acc_ready;
        end
        if (!got) check1("send_timeout", 1'b0, 1'b1);
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [63:0] exp_data, input logic exp_last);
        bit got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = data_valid;
        end
        check1({name, "_valid"}, got, 1'b1);
        check({name, "_data"}, data_out_packed, exp_data);
        check1({name, "_last"}, data_last, exp_last);
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        for (int k = 0; k < 1000 && !idle; k++) begin
            @(negedge clk);
            idle = !busy;
        end
        check1({name, "_idle"}, idle, 1'b1);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n          = 1'b1;
        start          = 1'b0;
        cfg_scale      = '0;
        cfg_shift      = '0;
        cfg_zero_point = '0;
        cfg_relu_en    = 1'b0;
        cfg_tile_beats = '0;
        acc_in_packed  = '0;
        acc_valid      = 1'b0;
        data_ready     = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        check1("rst_data_valid", data_valid, 1'b0);
        check1("rst_data_last", data_last, 1'b0);
        check("rst_data_out", data_out_packed, 64'd0);
        check1("rst_acc_ready", acc_ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic pass-through with exact latency.
        do_start(1, 0, 0, 0, 1);
        check1("basic_busy", busy, 1'b1);
        send(pk(0, 1, -1, 127, -128, 5, 6, 7));
        @(negedge clk); check1("basic_lat1", data_valid, 1'b0);
        @(negedge clk); check1("basic_lat2", data_valid, 1'b0);
        @(negedge clk);
        check1("basic_lat3", data_valid, 1'b1);
        check("basic_data", data_out_packed, 64'h070605807FFF0100);
        check1("basic_last", data_last, 1'b1);
        @(negedge clk); check1("basic_busy_drop", busy, 1'b0);
        wait_idle("basic");

        // Rounding.
        do_start(3, 2, 0, 0, 1);
        send(pk(5, -5, 0, 1, 2, -2, 100, -100));
        expect_out("round_a", 64'hB54BFF020100FC04, 1'b1);
        wait_idle("round_a");
        do_start(1, 2, 0, 0, 1);
        send(pk(6, 7, -6, -7, 1, 2, -1, -2));
        expect_out("round_b", 64'h00000100FEFF0202, 1'b1);
        wait_idle("round_b");

        // Saturation and ReLU with zero point.
        do_start(1, 0, 0, 0, 1);
        send(pk(1000, -1000, 127, -128, 0, 1, 2, 3));
        expect_out("sat", 64'h03020100807F807F, 1'b1);
        wait_idle("sat");
        check("sat_count_a", 64'(sat_count), SAT_EN ? 64'd2 : 64'd0);
        do_start(1, 0, 10, 1, 1);
        send(pk(-7, 0, 117, 118, -1000, 1000, -138, 5));
        expect_out("relu", 64'h0F0A7F0A7F7F0A0A, 1'b1);
        wait_idle("relu");
        check("sat_count_b", 64'(sat_count), SAT_EN ? 64'd2 : 64'd0);

        // Wide operands: large scale/shift, negative zero point (model only).
        do_start(65535, 31, 127, 0, 2);
        send(pk(32'sh7FFFFFFF, 32'sh80000000, 32768, -32769, 1, -1, 65536, -65536));
        send(pk(123456789, -123456789, 0, 2147, -2147, 99999, -99999, 7));
        wait_idle("wide_a");
        do_start(40000, 16, -20, 1, 1);
        send(pk(1, 2, 300, -300, 100, 1000, -5, 33));
        wait_idle("wide_b");
        check("sat_count_model", 64'(sat_count), SAT_EN ? 64'(m_sat) : 64'd0);

        // Backpressure in mid-stream.
        p0 = n_pop;
        do_start(1, 0, 0, 0, 4);
        fork
            begin
                for (int b = 0; b < 4; b++) send(pk(b, b + 10, -b, 20 * b, -20 * b, 1, 2, b + 100));
            end
            begin
                repeat (3) tick();
                data_ready = 1'b0;
                repeat (5) tick();
                data_ready = 1'b1;
            end
        join
        wait_idle("bp");
        check("bp_beats", 64'(n_pop - p0), 64'd4);

        // tile_beats = 0: each tile is a single last beat.
        for (int t = 0; t < 2; t++) begin
            do_start(2, 1, 0, 0, 0);
            send(pk(1, 2, 3, 4, 5, 6, 7, 8));
            expect_out("tb0", 64'h0807060504030201, 1'b1);
            wait_idle("tb0");
        end

        // Second start in RUN is ignored: beats use the first configuration.
        do_start(1, 0, 0, 0, 2);
        do_start(5, 3, 9, 1, 1);
        send(pk(1, 2, 3, 4, 5, 6, 7, 8));
        send(pk(-1, -2, -3, -4, -5, -6, -7, -8));
        expect_out("ign_b0", 64'h0807060504030201, 1'b0);
        expect_out("ign_b1", 64'hF8F9FAFBFCFDFEFF, 1'b1);
        wait_idle("ign");

        // start coincident with the final output handshake is ignored.
        data_ready = 1'b0;
        do_start(1, 0, 0, 0, 1);
        send(pk(9, 9, 9, 9, 9, 9, 9, 9));
        expect_out("coinc", 64'h0909090909090909, 1'b1);
        tick();
        data_ready     = 1'b1;
        cfg_scale      = 16'd7;
        cfg_tile_beats = 16'd3;
        start          = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check1("coinc_busy", busy, 1'b0);
        check1("coinc_valid", data_valid, 1'b0);
        check1("coinc_acc_ready", acc_ready, 1'b0);
        wait_idle("coinc");

        // Reset with two beats in flight.
        do_start(1, 0, 0, 0, 4);
        send(pk(11, 12, 13, 14, 15, 16, 17, 18));
        send(pk(21, 22, 23, 24, 25, 26, 27, 28));
        rst_n = 1'b0;
        #1;
        check1("mid_rst_valid", data_valid, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_acc_ready", acc_ready, 1'b0);
        check1("mid_rst_last", data_last, 1'b0);
        check("mid_rst_data", data_out_packed, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh tile after reset.
        do_start(1, 0, 0, 0, 1);
        send(pk(0, 1, -1, 127, -128, 5, 6, 7));
        expect_out("fresh", 64'h070605807FFF0100, 1'b1);
        wait_idle("fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/requant_stage.md
Name: requant_stage

Overview:
Pipelined requantizer between the systolic-array accumulator drain and the AXI4-Stream output stage. It converts ARRAY_COLS signed INT32 accumulators per beat into INT8 using per-tile scale, shift, zero point and optional ReLU. It tags the final beat of each tile with data_last and propagates downstream backpressure to the accumulator drain, so no beat is ever dropped.

Parameters:
ARRAY_COLS, 8, lanes per beat (ARRAY_COLS*OUT_WIDTH must equal the AXI data width, 64)
ACC_WIDTH, 32, signed accumulator width per lane
OUT_WIDTH, 8, signed output width per lane
MULT_WIDTH, 16, unsigned scale multiplier width
SHIFT_WIDTH, 5, right-shift amount width (0..31)
BEAT_CNT_WIDTH, 16, tile beat counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches cfg_*, clears beat counter, begins tile
cfg_scale  in  MULT_WIDTH  unsigned multiplier
cfg_shift  in  SHIFT_WIDTH  arithmetic right shift with rounding
cfg_zero_point  in  OUT_WIDTH  signed output offset
cfg_relu_en  in  1  clamp negative pre-offset results to 0
cfg_tile_beats  in  BEAT_CNT_WIDTH  beats per tile (0 treated as 1)
acc_in_packed  in  ACC_WIDTH*ARRAY_COLS  lane i at [i*ACC_WIDTH +: ACC_WIDTH]
acc_valid  in  1  input beat valid
acc_ready  out  1  input beat accepted when acc_valid && acc_ready
data_out_packed  out  OUT_WIDTH*ARRAY_COLS  lane i at [i*OUT_WIDTH +: OUT_WIDTH]
data_valid  out  1  output beat valid
data_last  out  1  last beat of tile, qualified by data_valid
data_ready  in  1  downstream can accept (top ties to !m_axis_tvalid || m_axis_tready)
busy  out  1  tile in progress
sat_count  out  16  saturated-lane count for current tile (see Optional Feature)

Behaviour:
- Reset: all pipeline valid bits 0, data_valid 0, data_last 0, data_out_packed 0, acc_ready 0, busy 0, beat counter 0, latched cfg 0, sat_count 0.
- Two phases: IDLE and RUN, plus a drain flag in_done.
  - start in IDLE: latch cfg, clear counter, in_done=0, enter RUN.
  - start in RUN: ignored.
- Pipeline: 3 stages (S1 multiply, S2 round/shift, S3 relu/offset/saturate) with global enable en = !data_valid || data_ready.
  - All stages advance together when en=1 and hold all state when en=0.
  - acc_ready = RUN && !in_done && en.
  - Latency: accepted beat appears on data_out_packed 3 cycles later when unstalled; throughput 1 beat/cycle.
- Arithmetic per lane, all signed with full precision and no intermediate truncation:
  - S1: p = acc * $signed({1'b0, scale}), ACC_WIDTH+MULT_WIDTH+1 bits.
  - S2: if shift>0, r = (p + (1<<(shift-1))) >>> shift (round half toward +inf); else r = p.
  - S3: if relu_en && r<0, r = 0; then v = r + zero_point. Saturate v to [-128, 127]; a lane is saturated when v lies outside that range.
- Last tagging:
  - Counter increments on each accepted input beat.
  - The beat with count == max(cfg_tile_beats,1)-1 carries a last tag through the pipeline, sets in_done, and wraps the counter to 0.
- busy = RUN. Return to IDLE on the cycle data_valid && data_ready && data_last.
- Simultaneous start with final output handshake: the handshake completes, start is ignored, and the block is IDLE next cycle.
- Reset mid-tile: pipeline contents discarded, all outputs return to reset values asynchronously.
- Stall: data_out_packed and data_last stay stable while data_valid && !data_ready.

Optional Feature:
- Macro REQUANT_SAT_COUNT_EN.
- When defined: sat_count counts saturated lanes as S3 results are registered, is cleared on accepted start, saturates at 16'hFFFF, and holds its value after the tile ends.
- When undefined: sat_count tied to 0 and the counting logic is absent.

Decomposition:
- pkg_accelerator: ACC_WIDTH, OUT_WIDTH, ARRAY_COLS, QUANT_MULT_WIDTH, QUANT_SHIFT_WIDTH, and typedef struct quant_cfg_t {scale, shift, zero_point, relu_en, tile_beats}.
- Sub-module requant_lane: one lane's 3-stage datapath with shared enable, plus a saturation flag output. Instantiate ARRAY_COLS copies via generate.
- Parent owns control, counter, valid/last pipeline and sat_count.

Test Plan:
- Basic: scale=1, shift=0, zp=0, tile_beats=1, lanes {0,1,-1,127,-128,5,6,7} -> identical INT8 lanes 3 cycles later, data_last=1, busy drops after handshake.
- Rounding: scale=3, shift=2, acc=5 -> 4 (15+2>>2); acc=-5 -> -4; acc=6, shift=2, scale=1 -> 2.
- Saturation and ReLU: acc=1000 -> 127; acc=-1000 -> -128; relu_en=1, zp=10, acc=-7 -> 10. With macro, sat_count=2 after the beat.
- Backpressure: tile_beats=4, data_ready low for 5 cycles mid-stream -> acc_ready low, output held stable, all 4 beats in order, last only on beat 4.
- tile_beats=0 -> every beat tagged last. A second start during RUN is ignored.
- Reset asserted with 2 beats in flight -> data_valid=0, busy=0 immediately. New start after release behaves as a fresh tile.
